// File: rtl/mlblock_config_loader_if.sv
// Handshake and serial-chain bundle between a configuration source and the
// MLBlock config loader. The master side is the controller plus the tile
// (it drives config_ret); the slave side is the loader itself.
interface mlblock_config_loader_if #(
    parameter int CHAIN_LEN = 64
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHAIN_LEN-1:0] cfg_word;
    logic                 stall;
    logic                 config_en;
    logic                 config_out;
    logic                 config_ret;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] readback;

    modport master (
        output cfg_valid, cfg_word, stall, config_ret,
        input  cfg_ready, config_en, config_out, busy, done, readback
    );

    modport slave (
        input  cfg_valid, cfg_word, stall, config_ret,
        output cfg_ready, config_en, config_out, busy, done, readback
    );
endinterface

// File: rtl/mlblock_config_loader.sv
// Serial configuration loader for one MLBlock tile. A parallel word is
// accepted on valid/ready, shifted out MSB first one bit per enabled cycle,
// while the old chain contents returning on config_ret are collected into
// readback (same bit ordering as cfg_word).
module mlblock_config_loader #(
    parameter int  CHAIN_LEN = 64,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    mlblock_config_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-1:0] readback_q, readback_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 shift_en;

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            readback_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            readback_q <= readback_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, shift on every unstalled SHIFT cycle,
    // leave SHIFT after the last of CHAIN_LEN enabled bits.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        readback_d = readback_q;
        cnt_d      = cnt_q;
        shift_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    shift_d = bus.cfg_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.stall) begin
                    shift_en   = 1'b1;
                    shift_d    = {shift_q[CHAIN_LEN-2:0], 1'b0};
                    readback_d = {readback_q[CHAIN_LEN-2:0], bus.config_ret};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // config_out is the MSB flop of the shift register, so it is registered
    // and naturally holds while stalled; it drains to 0 once the word is out.
    assign bus.cfg_ready  = (state_q == IDLE);
    assign bus.config_en  = shift_en;
    assign bus.config_out = shift_q[CHAIN_LEN-1];
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.readback   = readback_q;

endmodule

// File: tb/tb_mlblock_config_loader.sv
// Directed bench for mlblock_config_loader with CHAIN_LEN=8 and a
// behavioural model of the downstream tile chain.
module tb_mlblock_config_loader;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mlblock_config_loader_if #(.CHAIN_LEN(N)) ifc ();

    mlblock_config_loader #(.CHAIN_LEN(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Tile chain model: position 0 is nearest config_in, config_ret is the
    // far end. It is not reset, matching a real tile.
    logic [N-1:0] chain = '0;
    assign ifc.config_ret = chain[N-1];
    always @(posedge clk) begin
        if (ifc.config_en) chain <= {chain[N-2:0], ifc.config_out};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One load: cycle c is the clock period following the (c-1)th edge after
    // the accept edge. smask[c] drives stall during cycle c.
    task automatic do_load(input logic [N-1:0] word, input logic [15:0] smask,
                           input int exp_done, input logic [N-1:0] exp_rb,
                           input bit hold, input logic [N-1:0] hold_word);
        int           wait_cnt;
        int           done_c;
        int           n_en;
        logic [20:0]  en_obs;
        logic [20:0]  en_exp;
        logic [N-1:0] out_obs;
        logic         ready_at_done;
        logic         busy_at_done;
        logic [N-1:0] rb_at_done;
        logic [N-1:0] chain_at_done;
        wait_cnt = 0;
        done_c   = 0;
        n_en     = 0;
        en_obs   = '0;
        en_exp   = '0;
        out_obs  = '0;
        ready_at_done = 1'b1;
        busy_at_done  = 1'b0;
        rb_at_done    = '0;
        chain_at_done = '0;
        @(negedge clk);
        ifc.cfg_valid = 1'b1;
        ifc.cfg_word  = word;
        while (!ifc.cfg_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("accept_wait", 64'(wait_cnt < 50), 64'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            ifc.cfg_word = hold_word;
        end else begin
            ifc.cfg_valid = 1'b0;
            ifc.cfg_word  = ~word;
        end
        for (int c = 1; c <= 20; c++) begin
            ifc.stall = smask[c];
            @(negedge clk);
            en_obs[c] = ifc.config_en;
            if (ifc.config_en) begin
                out_obs = {out_obs[N-2:0], ifc.config_out};
                n_en++;
            end
            if (ifc.done) begin
                done_c        = c;
                ready_at_done = ifc.cfg_ready;
                busy_at_done  = ifc.busy;
                rb_at_done    = ifc.readback;
                chain_at_done = chain;
                break;
            end
            @(posedge clk);
            #1;
        end
        ifc.stall = 1'b0;
        for (int c = 1; c < exp_done; c++) en_exp[c] = ~smask[c];
        chk("done_cycle", 64'(done_c), 64'(exp_done));
        chk("en_pattern", 64'(en_obs), 64'(en_exp));
        chk("en_count", 64'(n_en), 64'(N));
        chk("out_bits", 64'(out_obs), 64'(word));
        chk("ready_at_done", 64'(ready_at_done), 64'd0);
        chk("busy_at_done", 64'(busy_at_done), 64'd1);
        chk("readback", 64'(rb_at_done), 64'(exp_rb));
        chk("chain", 64'(chain_at_done), 64'(word));
        $display("load word=%h stall=%h done_cycle=%0d readback=%h chain=%h",
                 word, smask, done_c, rb_at_done, chain_at_done);
    endtask

    initial begin
        ifc.cfg_valid = 1'b0;
        ifc.cfg_word  = '0;
        ifc.stall     = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ifc.cfg_ready), 64'd1);
        chk("rst_en", 64'(ifc.config_en), 64'd0);
        chk("rst_out", 64'(ifc.config_out), 64'd0);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_readback", 64'(ifc.readback), 64'd0);
        $display("reset held 3 cycles");
        @(posedge clk);
        #1 reset = 1'b0;

        do_load(8'hA5, 16'h0000, 9, 8'h00, 1'b0, 8'h00);
        do_load(8'h3C, 16'h0000, 9, 8'hA5, 1'b0, 8'h00);
        do_load(8'hFF, 16'h0024, 11, 8'h3C, 1'b0, 8'h00);
        do_load(8'h80, 16'h0000, 9, 8'hFF, 1'b1, 8'h11);
        do_load(8'h11, 16'h0000, 9, 8'h80, 1'b0, 8'h00);

        // Reset after four enabled bits of 0xF0.
        @(negedge clk);
        ifc.cfg_valid = 1'b1;
        ifc.cfg_word  = 8'hF0;
        chk("f0_ready", 64'(ifc.cfg_ready), 64'd1);
        @(posedge clk);
        #1 ifc.cfg_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_en", 64'(ifc.config_en), 64'd0);
        chk("mid_rst_busy", 64'(ifc.busy), 64'd0);
        chk("mid_rst_ready", 64'(ifc.cfg_ready), 64'd1);
        chk("mid_rst_readback", 64'(ifc.readback), 64'd0);
        begin
            logic saw_done;
            saw_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (ifc.done) saw_done = 1'b1;
            end
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            if (ifc.done) saw_done = 1'b1;
            chk("mid_rst_no_done", 64'(saw_done), 64'd0);
        end
        chk("mid_rst_chain", 64'(chain), 64'h1F);
        $display("reset mid-shift word=f0 chain=%h", chain);

        do_load(8'h5A, 16'h0000, 9, 8'h1F, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
